// File: rtl/gate_output_monitor.sv
// Edge counter and "D rise, G rise, D rise" pattern detector for the D/F/G gate outputs.
// Optional upstream consistency check (D and G both high) enabled by GATE_MONITOR_CONSISTENCY_CHECK_EN.
module gate_output_monitor #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             D,
  input  logic             F,
  input  logic             G,
  output logic [WIDTH-1:0] d_cnt,
  output logic [WIDTH-1:0] f_cnt,
  output logic [WIDTH-1:0] g_cnt,
  output logic             match,
  output logic [WIDTH-1:0] match_cnt,
  output logic [1:0]       state,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_D = 2'b01,
    GOT_G = 2'b10
  } state_t;

  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

  // Bit order everywhere: [0]=D, [1]=F, [2]=G
  logic [2:0] in_vec;
  logic [2:0] s_reg;
  logic [2:0] p_reg;
  logic [2:0] rise;

  assign in_vec = {G, F, D};
  assign rise   = s_reg & ~p_reg;

  // Sampling runs regardless of en, so edges seen while disabled are consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg <= 3'b000;
      p_reg <= 3'b000;
    end else begin
      s_reg <= in_vec;
      p_reg <= s_reg;
    end
  end

  logic [2:0][WIDTH-1:0] cnt_all;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge_cnt
      logic [WIDTH-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt_reg <= '0;
        end else if (en && rise[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end

      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       timer_reg;
  logic [7:0]       timer_next;
  logic             match_reg;
  logic             match_next;
  logic [WIDTH-1:0] match_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= 8'd0;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      match_reg <= match_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match_cnt_reg <= '0;
    end else if (match_next && (match_cnt_reg != CNT_MAX)) begin
      match_cnt_reg <= match_cnt_reg + CNT_ONE;
    end
  end

  // A new D rise in GOT_G both completes a match and starts the next pattern
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    match_next = 1'b0;
    if (en) begin
      case (state_reg)
        IDLE: begin
          if (rise[0]) begin
            state_next = GOT_D;
            timer_next = 8'd0;
          end
        end
        GOT_D: begin
          if (rise[2]) begin
            state_next = GOT_G;
            timer_next = 8'd0;
          end else if (rise[0]) begin
            timer_next = 8'd0;
          end else if (timer_reg == TIMER_LAST) begin
            state_next = IDLE;
            timer_next = 8'd0;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
        GOT_G: begin
          if (rise[0]) begin
            state_next = GOT_D;
            timer_next = 8'd0;
            match_next = 1'b1;
          end else if (timer_reg == TIMER_LAST) begin
            state_next = IDLE;
            timer_next = 8'd0;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    d_cnt     = cnt_all[0];
    f_cnt     = cnt_all[1];
    g_cnt     = cnt_all[2];
    match     = match_reg;
    match_cnt = match_cnt_reg;
    state     = state_reg;
  end

`ifdef GATE_MONITOR_CONSISTENCY_CHECK_EN
  // D needs A=1 and G needs A=0, so both sampled high means a broken upstream stage
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (s_reg[0] && s_reg[2]) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
